// File: rtl/sram_arbiter.sv
// Two-requester arbiter in front of a single-port SRAM with one-cycle read latency.
// Define ARB_ROUND_ROBIN_EN for round-robin tie-breaking; otherwise data wins ties.
module sram_arbiter #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,

    input  logic            inst_req_en,
    input  logic [3:0]      inst_req_wen,
    input  logic [XLEN-1:0] inst_req_addr,
    input  logic [XLEN-1:0] inst_req_wdata,
    output logic            inst_req_ready,
    output logic            inst_rsp_valid,
    output logic [XLEN-1:0] inst_rsp_rdata,
    input  logic            inst_rsp_ready,

    input  logic            data_req_en,
    input  logic [3:0]      data_req_wen,
    input  logic [XLEN-1:0] data_req_addr,
    input  logic [XLEN-1:0] data_req_wdata,
    output logic            data_req_ready,
    output logic            data_rsp_valid,
    output logic [XLEN-1:0] data_rsp_rdata,
    input  logic            data_rsp_ready,

    output logic            mem_en,
    output logic [3:0]      mem_wen,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    input  logic [XLEN-1:0] mem_rdata
);

    logic            pendInst_q, pendInst_d;
    logic            pendData_q, pendData_d;
    logic            holdValidInst_q, holdValidInst_d;
    logic            holdValidData_q, holdValidData_d;
    logic [XLEN-1:0] holdInst_q, holdInst_d;
    logic [XLEN-1:0] holdData_q, holdData_d;

    logic eligInst, eligData;
    logic grantInst, grantData;

`ifdef ARB_ROUND_ROBIN_EN
    typedef enum logic {
        SRC_INST = 1'b0,
        SRC_DATA = 1'b1
    } src_e;

    src_e lastGrant_q, lastGrant_d;
`endif

    // A side with a read in flight (pending or held) may not issue again.
    assign eligInst = inst_req_en && !pendInst_q && !holdValidInst_q;
    assign eligData = data_req_en && !pendData_q && !holdValidData_q;

    always_comb begin
        grantInst = 1'b0;
        grantData = 1'b0;
        if (!reset) begin
            if (eligInst && eligData) begin
`ifdef ARB_ROUND_ROBIN_EN
                grantInst = (lastGrant_q == SRC_DATA);
                grantData = (lastGrant_q == SRC_INST);
`else
                grantData = 1'b1;
`endif
            end else begin
                grantInst = eligInst;
                grantData = eligData;
            end
        end
    end

    always_comb begin
        inst_req_ready = grantInst;
        data_req_ready = grantData;
        mem_en         = grantInst || grantData;
        mem_wen        = '0;
        mem_addr       = '0;
        mem_wdata      = '0;
        if (grantInst) begin
            mem_wen   = inst_req_wen;
            mem_addr  = inst_req_addr;
            mem_wdata = inst_req_wdata;
        end else if (grantData) begin
            mem_wen   = data_req_wen;
            mem_addr  = data_req_addr;
            mem_wdata = data_req_wdata;
        end
    end

    // Read data passes straight through in the pending cycle unless a held copy exists.
    always_comb begin
        inst_rsp_valid = pendInst_q || holdValidInst_q;
        data_rsp_valid = pendData_q || holdValidData_q;
        inst_rsp_rdata = '0;
        data_rsp_rdata = '0;
        if (holdValidInst_q) begin
            inst_rsp_rdata = holdInst_q;
        end else if (pendInst_q) begin
            inst_rsp_rdata = mem_rdata;
        end
        if (holdValidData_q) begin
            data_rsp_rdata = holdData_q;
        end else if (pendData_q) begin
            data_rsp_rdata = mem_rdata;
        end
    end

    always_comb begin
        pendInst_d      = grantInst && (inst_req_wen == 4'b0000);
        pendData_d      = grantData && (data_req_wen == 4'b0000);
        holdValidInst_d = holdValidInst_q;
        holdValidData_d = holdValidData_q;
        holdInst_d      = holdInst_q;
        holdData_d      = holdData_q;
        if (pendInst_q && !inst_rsp_ready) begin
            holdValidInst_d = 1'b1;
            holdInst_d      = mem_rdata;
        end else if (holdValidInst_q && inst_rsp_ready) begin
            holdValidInst_d = 1'b0;
        end
        if (pendData_q && !data_rsp_ready) begin
            holdValidData_d = 1'b1;
            holdData_d      = mem_rdata;
        end else if (holdValidData_q && data_rsp_ready) begin
            holdValidData_d = 1'b0;
        end
    end

`ifdef ARB_ROUND_ROBIN_EN
    always_comb begin
        lastGrant_d = lastGrant_q;
        if (grantInst) begin
            lastGrant_d = SRC_INST;
        end else if (grantData) begin
            lastGrant_d = SRC_DATA;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lastGrant_q <= SRC_DATA;
        end else begin
            lastGrant_q <= lastGrant_d;
        end
    end
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pendInst_q      <= 1'b0;
            pendData_q      <= 1'b0;
            holdValidInst_q <= 1'b0;
            holdValidData_q <= 1'b0;
        end else begin
            pendInst_q      <= pendInst_d;
            pendData_q      <= pendData_d;
            holdValidInst_q <= holdValidInst_d;
            holdValidData_q <= holdValidData_d;
        end
    end

    // Held data is only visible behind its valid flag, so it carries no reset.
    always_ff @(posedge clk) begin
        holdInst_q <= holdInst_d;
        holdData_q <= holdData_d;
    end

endmodule
